// File: rtl/tip_hello_axi_mem_checker.sv
// AXI master memory self-test: writes a seed-derived pattern over a region
// with INCR bursts, reads it back, and reports error count / first bad word.
module tip_hello_axi_mem_checker #(
  parameter int BW_ADDR    = 32,
  parameter int BW_DATA    = 128,
  parameter int BW_AXI_TID = 4,
  parameter int TID_VALUE  = 0,
  parameter int MAX_BURST  = 16
) (
  input  logic                    clk,
  input  logic                    rstnn,
  input  logic                    start,
  input  logic [BW_ADDR-1:0]      cfg_base,
  input  logic [15:0]             cfg_num_words,
  input  logic [31:0]             cfg_seed,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [15:0]             err_count,
  output logic [15:0]             first_err_index,
  output logic [BW_AXI_TID-1:0]   txawid,
  output logic [BW_ADDR-1:0]      txawaddr,
  output logic [3:0]              txawlen,
  output logic [2:0]              txawsize,
  output logic [1:0]              txawburst,
  output logic                    txawvalid,
  input  logic                    txawready,
  output logic [BW_AXI_TID-1:0]   txwid,
  output logic [BW_DATA-1:0]      txwdata,
  output logic [BW_DATA/8-1:0]    txwstrb,
  output logic                    txwlast,
  output logic                    txwvalid,
  input  logic                    txwready,
  input  logic [BW_AXI_TID-1:0]   txbid,
  input  logic [1:0]              txbresp,
  input  logic                    txbvalid,
  output logic                    txbready,
  output logic [BW_AXI_TID-1:0]   txarid,
  output logic [BW_ADDR-1:0]      txaraddr,
  output logic [3:0]              txarlen,
  output logic [2:0]              txarsize,
  output logic [1:0]              txarburst,
  output logic                    txarvalid,
  input  logic                    txarready,
  input  logic [BW_AXI_TID-1:0]   txrid,
  input  logic [BW_DATA-1:0]      txrdata,
  input  logic [1:0]              txrresp,
  input  logic                    txrlast,
  input  logic                    txrvalid,
  output logic                    txrready
);

  localparam int NB = BW_DATA / 8;
  localparam int SZ = $clog2(NB);
  localparam int NW = BW_DATA / 32;

  typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [BW_ADDR-9:0]   base_q, base_d;
  logic [15:0]          num_q, num_d, idx_q, idx_d;
  logic [15:0]          err_q, err_d, first_q, first_d;
  logic [31:0]          seed_q, seed_d;
  logic [3:0]           beat_q, beat_d, len_q, len_d;
  logic [BW_ADDR-1:0]   addr_q, addr_d;
  logic [BW_DATA-1:0]   wdata_q, wdata_d;
  logic                 wlast_q, wlast_d;
  logic                 awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic                 arvalid_q, arvalid_d, rready_q, rready_d;
  logic                 busy_q, busy_d, done_q, done_d, pass_q, pass_d;

  logic [15:0]          rem;
  logic [3:0]           blen;
  logic [1:0]           err_inc;
  logic [16:0]          err_sum;
  logic                 r_mismatch, r_last_beat;
  logic                 unused_inputs;

  assign unused_inputs = ^{txbid, txrid, cfg_base[7:0]};

  function automatic logic [BW_DATA-1:0] pattern(input logic [31:0] w);
    return {NW{w}};
  endfunction

  // Next-state, counters and registered channel outputs
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    num_d     = num_q;
    idx_d     = idx_q;
    err_d     = err_q;
    first_d   = first_q;
    seed_d    = seed_q;
    beat_d    = beat_q;
    len_d     = len_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    pass_d    = pass_q;
    done_d    = 1'b0;
    err_inc   = '0;
    r_last_beat = (beat_q == len_q);
    r_mismatch  = (txrdata != pattern(seed_q + 32'(idx_q)));

    case (state_q)
      S_IDLE: if (start) begin
        base_d  = cfg_base[BW_ADDR-1:8];
        num_d   = cfg_num_words;
        seed_d  = cfg_seed;
        idx_d   = '0;
        err_d   = '0;
        first_d = '1;
        pass_d  = 1'b0;
        state_d = (cfg_num_words == '0) ? S_DONE : S_AW;
      end
      S_AW: if (txawready) begin
        state_d = S_W;
        beat_d  = '0;
      end
      S_W: if (txwready) begin
        idx_d  = idx_q + 16'd1;
        beat_d = beat_q + 4'd1;
        if (beat_q == len_q) state_d = S_B;
      end
      S_B: if (txbvalid) begin
        if (txbresp != 2'b00) err_inc = 2'd1;
        if (idx_q < num_q) begin
          state_d = S_AW;
        end else begin
          state_d = S_AR;
          idx_d   = '0;
        end
      end
      S_AR: if (txarready) begin
        state_d = S_R;
        beat_d  = '0;
      end
      S_R: if (txrvalid) begin
        err_inc = 2'(r_mismatch) + 2'(txrresp != 2'b00) + 2'(txrlast != r_last_beat);
        if (r_mismatch && first_q == '1) first_d = idx_q;
        idx_d  = idx_q + 16'd1;
        beat_d = beat_q + 4'd1;
        if (r_last_beat) state_d = (idx_d < num_q) ? S_AR : S_DONE;
      end
      S_DONE: begin
        done_d  = 1'b1;
        pass_d  = (err_q == '0);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    err_sum = {1'b0, err_q} + 17'(err_inc);
    if (err_inc != '0) err_d = err_sum[16] ? '1 : err_sum[15:0];

    // Payload flops are loaded from next-state values so they are valid
    // in the same cycle the matching valid flop rises.
    rem  = num_d - idx_d;
    blen = (rem >= 16'(MAX_BURST)) ? 4'(MAX_BURST - 1) : 4'(rem - 16'd1);
    if ((state_d == S_AW || state_d == S_AR) && state_d != state_q) begin
      len_d  = blen;
      addr_d = {base_d, 8'h00} + (BW_ADDR'(idx_d) << SZ);
    end
    if (state_d == S_W) wdata_d = pattern(seed_d + 32'(idx_d));
    wlast_d   = (state_d == S_W) && (beat_d == len_d);
    awvalid_d = (state_d == S_AW);
    wvalid_d  = (state_d == S_W);
    bready_d  = (state_d == S_B);
    arvalid_d = (state_d == S_AR);
    rready_d  = (state_d == S_R);
    busy_d    = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state_q   <= S_IDLE;
      base_q    <= '0;
      num_q     <= '0;
      idx_q     <= '0;
      err_q     <= '0;
      first_q   <= '1;
      seed_q    <= '0;
      beat_q    <= '0;
      len_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wlast_q   <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      num_q     <= num_d;
      idx_q     <= idx_d;
      err_q     <= err_d;
      first_q   <= first_d;
      seed_q    <= seed_d;
      beat_q    <= beat_d;
      len_q     <= len_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wlast_q   <= wlast_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_count       = err_q;
  assign first_err_index = first_q;

  assign txawid    = BW_AXI_TID'(TID_VALUE);
  assign txawaddr  = addr_q;
  assign txawlen   = len_q;
  assign txawsize  = 3'(SZ);
  assign txawburst = 2'b01;
  assign txawvalid = awvalid_q;

  assign txwid     = BW_AXI_TID'(TID_VALUE);
  assign txwdata   = wdata_q;
  assign txwstrb   = '1;
  assign txwlast   = wlast_q;
  assign txwvalid  = wvalid_q;

  assign txbready  = bready_q;

  assign txarid    = BW_AXI_TID'(TID_VALUE);
  assign txaraddr  = addr_q;
  assign txarlen   = len_q;
  assign txarsize  = 3'(SZ);
  assign txarburst = 2'b01;
  assign txarvalid = arvalid_q;

  assign txrready  = rready_q;

endmodule

// File: tb/tb_tip_hello_axi_mem_checker.sv
// Bench for tip_hello_axi_mem_checker: AXI slave model with optional stalls,
// read corruption and error responses; scoreboard monitor checks traffic/results.
module tb_tip_hello_axi_mem_checker;

  logic         clk = 1'b0;
  logic         rstnn = 1'b1;
  logic         start = 1'b0;
  logic [31:0]  cfg_base = '0;
  logic [15:0]  cfg_num_words = '0;
  logic [31:0]  cfg_seed = '0;
  logic         busy, done, pass;
  logic [15:0]  err_count, first_err_index;
  logic [3:0]   txawid, txwid, txarid;
  logic [31:0]  txawaddr, txaraddr;
  logic [3:0]   txawlen, txarlen;
  logic [2:0]   txawsize, txarsize;
  logic [1:0]   txawburst, txarburst;
  logic         txawvalid, txwvalid, txarvalid, txwlast, txbready, txrready;
  logic [127:0] txwdata;
  logic [15:0]  txwstrb;
  logic         txawready = 1'b0, txwready = 1'b0, txarready = 1'b0;
  logic [3:0]   txbid = '0, txrid = '0;
  logic [1:0]   txbresp = '0, txrresp = '0;
  logic         txbvalid = 1'b0, txrvalid = 1'b0, txrlast = 1'b0;
  logic [127:0] txrdata = '0;

  always #5 clk = ~clk;

  tip_hello_axi_mem_checker #(
    .BW_ADDR(32), .BW_DATA(128), .BW_AXI_TID(4), .TID_VALUE(0), .MAX_BURST(16)
  ) dut (
    .clk(clk), .rstnn(rstnn), .start(start),
    .cfg_base(cfg_base), .cfg_num_words(cfg_num_words), .cfg_seed(cfg_seed),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_index(first_err_index),
    .txawid(txawid), .txawaddr(txawaddr), .txawlen(txawlen), .txawsize(txawsize),
    .txawburst(txawburst), .txawvalid(txawvalid), .txawready(txawready),
    .txwid(txwid), .txwdata(txwdata), .txwstrb(txwstrb), .txwlast(txwlast),
    .txwvalid(txwvalid), .txwready(txwready),
    .txbid(txbid), .txbresp(txbresp), .txbvalid(txbvalid), .txbready(txbready),
    .txarid(txarid), .txaraddr(txaraddr), .txarlen(txarlen), .txarsize(txarsize),
    .txarburst(txarburst), .txarvalid(txarvalid), .txarready(txarready),
    .txrid(txrid), .txrdata(txrdata), .txrresp(txrresp), .txrlast(txrlast),
    .txrvalid(txrvalid), .txrready(txrready)
  );

  typedef struct packed { logic [31:0] addr; logic [3:0] len; } ad_t;
  typedef struct packed { logic [127:0] data; logic last; } wb_t;
  typedef struct packed { logic [15:0] err; logic [15:0] first; logic pass; } res_t;

  ad_t  exp_aw[$];
  ad_t  exp_ar[$];
  wb_t  exp_w[$];
  res_t exp_res[$];

  int total = 0;
  int bad   = 0;

  int           stall_max = 0;
  logic         bresp_err = 1'b0;
  logic         corrupt_en = 1'b0;
  logic [31:0]  corrupt_addr = '0;
  int           aw_cnt = 0;
  int           ar_cnt = 0;
  logic [127:0] mem [0:1023];

  function automatic logic [127:0] pat(input logic [31:0] w);
    return {4{w}};
  endfunction

  function automatic int rnd_stall();
    return (stall_max > 0) ? int'($urandom_range(stall_max, 0)) : 0;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // AXI slave model, evaluated at negedge with blocking drives
  initial begin : slave
    int ss, stall, wcnt, rcnt, wlen, rlen;
    logic [31:0] waddr, raddr;
    bit b_pend, r_pend;
    ss = 0; stall = 0; wcnt = 0; rcnt = 0; wlen = 0; rlen = 0;
    waddr = '0; raddr = '0; b_pend = 0; r_pend = 0;
    forever begin
      @(negedge clk);
      txawready = 1'b0; txwready = 1'b0; txarready = 1'b0;
      if (!rstnn) begin
        ss = 0; stall = 0; b_pend = 0; r_pend = 0;
        txbvalid = 1'b0; txrvalid = 1'b0; txrlast = 1'b0;
      end else begin
        if (b_pend) begin b_pend = 0; txbvalid = 1'b0; ss = 0; end
        if (r_pend) begin
          r_pend = 0; txrvalid = 1'b0; rcnt++; raddr += 32'd16;
          if (rcnt > rlen) ss = 0;
        end
        case (ss)
          0: if (txawvalid) begin
               if (stall > 0) stall--;
               else begin
                 txawready = 1'b1; aw_cnt++;
                 waddr = txawaddr; wlen = int'(txawlen); wcnt = 0; ss = 1; stall = rnd_stall();
               end
             end else if (txarvalid) begin
               if (stall > 0) stall--;
               else begin
                 txarready = 1'b1; ar_cnt++;
                 raddr = txaraddr; rlen = int'(txarlen); rcnt = 0; ss = 3; stall = rnd_stall();
               end
             end
          1: if (txwvalid) begin
               if (stall > 0) stall--;
               else begin
                 txwready = 1'b1;
                 mem[waddr[13:4]] = txwdata;
                 waddr += 32'd16; wcnt++; stall = rnd_stall();
                 if (wcnt > wlen) ss = 2;
               end
             end
          2: if (!txbvalid) begin
               if (stall > 0) stall--;
               else begin
                 txbvalid = 1'b1; txbresp = bresp_err ? 2'b10 : 2'b00; stall = rnd_stall();
               end
             end
          3: if (!txrvalid) begin
               if (stall > 0) stall--;
               else begin
                 txrvalid = 1'b1;
                 txrdata  = mem[raddr[13:4]];
                 if (corrupt_en && raddr == corrupt_addr) txrdata[0] = ~txrdata[0];
                 txrlast  = (rcnt == rlen);
                 txrresp  = 2'b00;
                 stall    = rnd_stall();
               end
             end
          default: ss = 0;
        endcase
        if (txbvalid && txbready) b_pend = 1;
        if (txrvalid && txrready) r_pend = 1;
      end
    end
  end

  // Scoreboard monitor: pops expectations on handshakes and done pulses
  initial begin : monitor
    ad_t a; wb_t w; res_t r;
    logic [35:0]  p_aw, p_ar;
    logic [128:0] p_w;
    bit p_aw_wait, p_w_wait, p_ar_wait;
    p_aw_wait = 0; p_w_wait = 0; p_ar_wait = 0;
    p_aw = '0; p_ar = '0; p_w = '0;
    forever begin
      @(negedge clk); #1;
      if (!rstnn) begin
        p_aw_wait = 0; p_w_wait = 0; p_ar_wait = 0;
      end else begin
        if (p_aw_wait) chk("aw_hold", {txawvalid, txawaddr, txawlen}, {1'b1, p_aw});
        if (p_w_wait)  chk("w_hold",  {txwvalid, txwdata, txwlast}, {1'b1, p_w});
        if (p_ar_wait) chk("ar_hold", {txarvalid, txaraddr, txarlen}, {1'b1, p_ar});
        p_aw_wait = txawvalid && !txawready; p_aw = {txawaddr, txawlen};
        p_w_wait  = txwvalid && !txwready;   p_w  = {txwdata, txwlast};
        p_ar_wait = txarvalid && !txarready; p_ar = {txaraddr, txarlen};

        if (txawvalid && txawready) begin
          if (exp_aw.size() == 0) begin
            total++; bad++;
            $display("FAIL aw_unexpected: got addr %h len %0d expected no AW", txawaddr, txawlen);
          end else begin
            a = exp_aw.pop_front();
            chk("aw", {txawaddr, txawlen, txawsize, txawburst, txawid},
                      {a.addr, a.len, 3'd4, 2'b01, 4'd0});
          end
        end
        if (txwvalid && txwready) begin
          if (exp_w.size() == 0) begin
            total++; bad++;
            $display("FAIL w_unexpected: got data %h expected no W", txwdata);
          end else begin
            w = exp_w.pop_front();
            chk("w", {txwdata, txwlast, txwstrb, txwid}, {w.data, w.last, 16'hffff, 4'd0});
          end
        end
        if (txarvalid && txarready) begin
          if (exp_ar.size() == 0) begin
            total++; bad++;
            $display("FAIL ar_unexpected: got addr %h len %0d expected no AR", txaraddr, txarlen);
          end else begin
            a = exp_ar.pop_front();
            chk("ar", {txaraddr, txarlen, txarsize, txarburst, txarid},
                      {a.addr, a.len, 3'd4, 2'b01, 4'd0});
          end
        end
        if (done) begin
          if (exp_res.size() == 0) begin
            total++; bad++;
            $display("FAIL done_unexpected: got done expected none");
          end else begin
            r = exp_res.pop_front();
            chk("result", {err_count, first_err_index, pass}, {r.err, r.first, r.pass});
          end
        end
      end
    end
  end

  task automatic expect_run(input logic [31:0] base, input int n, input logic [31:0] seed,
                            input logic [15:0] err, input logic [15:0] first, input logic ok);
    ad_t a; wb_t w; res_t r;
    for (int k = 0; k < n; k += 16) begin
      int b;
      b = (n - k > 16) ? 16 : n - k;
      a.addr = base + 32'(k * 16);
      a.len  = 4'(b - 1);
      exp_aw.push_back(a);
      exp_ar.push_back(a);
      for (int j = 0; j < b; j++) begin
        w.data = pat(seed + 32'(k + j));
        w.last = (j == b - 1);
        exp_w.push_back(w);
      end
    end
    r.err = err; r.first = first; r.pass = ok;
    exp_res.push_back(r);
  endtask

  task automatic pulse_start(input logic [31:0] base, input logic [15:0] n, input logic [31:0] seed);
    @(posedge clk); #2;
    cfg_base = base; cfg_num_words = n; cfg_seed = seed; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 1;
    while (done !== 1'b1 && cycles < 20000) begin
      @(posedge clk); #2;
      cycles++;
    end
    if (done !== 1'b1) begin
      total++; bad++;
      $display("FAIL done_timeout: got no done after %0d cycles expected done", cycles);
    end
    repeat (2) begin @(posedge clk); #2; end
    chk("drained", 128'(exp_aw.size() + exp_w.size() + exp_ar.size() + exp_res.size()), 128'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_status"}, {busy, done, pass, err_count, first_err_index},
                          {1'b0, 1'b0, 1'b0, 16'h0000, 16'hffff});
    chk({tag, "_valids"}, {txawvalid, txwvalid, txarvalid, txbready, txrready, txwlast},
                          6'b000000);
    chk({tag, "_addr"}, {txawaddr, txaraddr}, 64'h0);
    chk({tag, "_wdata"}, txwdata, 128'h0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish expected test end");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int cyc, aw0, ar0;
    #1 rstnn = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("reset");
    rstnn = 1'b1;

    // 1: ideal slave, 40 words -> bursts len 15,15,7
    aw0 = aw_cnt; ar0 = ar_cnt;
    expect_run(32'h1000, 40, 32'h100, 16'd0, 16'hffff, 1'b1);
    pulse_start(32'h1000, 16'd40, 32'h100);
    chk("busy_running", busy, 1'b1);
    wait_done(cyc);
    chk("ideal_bursts", {32'(aw_cnt - aw0), 32'(ar_cnt - ar0)}, {32'd3, 32'd3});

    // 2: read word 21 corrupted
    corrupt_en = 1'b1; corrupt_addr = 32'h1000 + 32'(21 * 16);
    expect_run(32'h1000, 40, 32'h100, 16'd1, 16'd21, 1'b0);
    pulse_start(32'h1000, 16'd40, 32'h100);
    wait_done(cyc);
    corrupt_en = 1'b0;
    chk("corrupt_idle", busy, 1'b0);

    // 3: SLVERR on write response, 3 words
    bresp_err = 1'b1;
    aw0 = aw_cnt; ar0 = ar_cnt;
    expect_run(32'h1000, 3, 32'h100, 16'd1, 16'hffff, 1'b0);
    pulse_start(32'h1000, 16'd3, 32'h100);
    wait_done(cyc);
    bresp_err = 1'b0;
    chk("slverr_bursts", {32'(aw_cnt - aw0), 32'(ar_cnt - ar0)}, {32'd1, 32'd1});

    // 4: random stalls, same config as ideal run; base low bits ignored
    stall_max = 5;
    expect_run(32'h1000, 40, 32'h100, 16'd0, 16'hffff, 1'b1);
    pulse_start(32'h10a7, 16'd40, 32'h100);
    wait_done(cyc);
    stall_max = 0;

    // 5: zero words -> no traffic, done two cycles after start
    expect_run(32'h2000, 0, 32'h0, 16'd0, 16'hffff, 1'b1);
    pulse_start(32'h2000, 16'd0, 32'h0);
    wait_done(cyc);
    chk("zero_done_latency", 128'(cyc), 128'd2);

    // 6: reset during W of the second burst, then a full clean run
    aw0 = aw_cnt;
    expect_run(32'h1000, 40, 32'h200, 16'd0, 16'hffff, 1'b1);
    pulse_start(32'h1000, 16'd40, 32'h200);
    cyc = 0;
    while (!(aw_cnt >= aw0 + 2 && txwvalid === 1'b1) && cyc < 2000) begin
      @(posedge clk); #2;
      cyc++;
    end
    chk("reached_burst2_w", {(aw_cnt >= aw0 + 2), txwvalid}, 2'b11);
    rstnn = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_aw.delete(); exp_w.delete(); exp_ar.delete(); exp_res.delete();
    repeat (2) @(posedge clk);
    #2 rstnn = 1'b1;
    expect_run(32'h3000, 40, 32'h55, 16'd0, 16'hffff, 1'b1);
    pulse_start(32'h3000, 16'd40, 32'h55);
    wait_done(cyc);
    chk("post_reset_pass", {pass, err_count}, {1'b1, 16'd0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tip_hello_axi_mem_checker.md
Name: tip_hello_axi_mem_checker

Overview:
- AXI master traffic generator/checker; the initiator end of the protocol served by the tip_hello SRAM AXI slave.
- On a start pulse, writes a seed-derived pattern into a region with INCR bursts, reads the region back and compares.
- Reports pass/fail, the error count and the first failing word index.
- Connects as a master port on the munoc; used for platform bring-up and memory self-test.

Parameters:
- BW_ADDR, 32, AXI address width.
- BW_DATA, 128, AXI data width; must be a multiple of 32.
- BW_AXI_TID, 4, AXI ID width; all transactions use ID = TID_VALUE.
- TID_VALUE, 0, fixed transaction ID.
- MAX_BURST, 16, maximum beats per burst (1..16).

Ports:
- clk  in  1  clock
- rstnn  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; ignored while busy=1
- cfg_base  in  BW_ADDR  region base; bits [7:0] treated as 0
- cfg_num_words  in  16  words to test; 0 means no AXI traffic
- cfg_seed  in  32  pattern seed
- busy  out  1  test in progress
- done  out  1  one-cycle pulse at completion
- pass  out  1  1 when err_count==0; valid from done until next start
- err_count  out  16  data-mismatch count plus non-OKAY response count, saturating at 0xFFFF
- first_err_index  out  16  word index of the first data mismatch; 0xFFFF if none
- txawid/txawaddr/txawlen/txawsize/txawburst/txawvalid  out  TID/BW_ADDR/4/3/2/1  AW channel
- txawready  in  1  AW channel
- txwid/txwdata/txwstrb/txwlast/txwvalid  out  TID/BW_DATA/BW_DATA/8/1/1  W channel
- txwready  in  1  W channel
- txbid/txbresp/txbvalid  in  TID/2/1  B channel
- txbready  out  1  B channel
- txarid/txaraddr/txarlen/txarsize/txarburst/txarvalid  out  as AW  AR channel
- txarready  in  1  AR channel
- txrid/txrdata/txrresp/txrlast/txrvalid  in  TID/BW_DATA/2/1/1  R channel
- txrready  out  1  R channel

Behaviour:
- Reset (async, rstnn=0): state IDLE; all valid/ready outputs 0; busy=0, done=0, pass=0, err_count=0, first_err_index=0xFFFF; address/data outputs 0.
- Pattern: word k = BW_DATA/32 copies of (cfg_seed + k) mod 2^32. Address of word k = {cfg_base[BW_ADDR-1:8], 8'h0} + k*BW_DATA/8.
- Burst attributes: size = log2(BW_DATA/8); burst = INCR; len = min(MAX_BURST, remaining) - 1; wstrb all ones. With 256-byte base alignment and MAX_BURST*16B <= 256B, no burst crosses 4KB.
- Only one transaction is outstanding; AW and W are sequential, never concurrent.
- start latches cfg_* into internal registers and clears err_count and first_err_index.
- IDLE -> start -> AW. If cfg_num_words=0, go directly to DONE.
- AW: awvalid=1 until awready -> W.
- W: wvalid=1. Advance beat on wvalid&wready. wlast=1 on the final beat of the burst; after it -> B.
- B: bready=1; on bvalid, a bresp!=OKAY increments err_count. If words remain -> AW; else -> AR with the word index reset to 0.
- AR: arvalid=1 until arready -> R.
- R: rready=1. Per beat:
  - A mismatch against the expected word increments err_count and sets first_err_index if still 0xFFFF.
  - rresp!=OKAY increments err_count (a beat can add 2).
  - After the beat with rlast=1: words remain -> AR; else -> DONE.
  - rlast on the wrong beat counts one error; the FSM still advances on the beat count.
- DONE: done=1 for one cycle; pass=(err_count==0); -> IDLE. busy=1 in every state except IDLE.
- Valid signals never drop without the matching ready; address/data are stable while valid=1.
- Reset mid-test returns to IDLE immediately; any in-flight transaction is abandoned.

Test Plan:
- base=0x0000_1000, num_words=40, seed=0x100, ideal SRAM slave -> AW bursts with len 15,15,7 at 0x1000/0x1100/0x1200; read back matches; done pulse; pass=1, err_count=0, first_err_index=0xFFFF.
- Same config; slave corrupts read word 21 -> err_count=1, first_err_index=21, pass=0.
- num_words=3; slave returns bresp=SLVERR -> err_count=1, pass=0; exactly one AW (len=2) and one AR (len=2).
- Random awready/wready/arready/rvalid/bvalid stalls, 0–5 cycles -> payload held stable under valid; result identical to the ideal run.
- num_words=0 -> no valid ever asserted; done 2 cycles after start; pass=1.
- rstnn pulsed low during the W phase of burst 2 -> all outputs at reset values; a following start runs a full correct test.
